// File: rtl/rom_loader.sv
// Copies a combinational program ROM into RAM as little-endian 32-bit words, one write request per word.
// Latency: 4 FETCH cycles per full word plus WRITE cycles until mem_write_ack; the request holds until it is acknowledged.
// Backpressure: mem_write_req holds its address and data steady until the RAM acknowledges.
module rom_loader #(
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int          MAX_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] rom_address,
    input  logic [7:0]  rom_byte,
    input  logic        rom_done,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_write_req,
    input  logic        mem_write_ack,
    output logic        busy,
    output logic        loaded,
    output logic        overflow,
    output logic [15:0] word_count
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    localparam logic [31:0] LAST_ADDR = 32'(MAX_BYTES - 1);

    state_t      state_q, state_d;
    logic [31:0] rom_addr_q, rom_addr_d;
    logic [31:0] word_q, word_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        last_q, last_d;
    logic        ovf_q, ovf_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        at_max;

    assign at_max = (rom_addr_q == LAST_ADDR);

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        word_d     = word_q;
        mem_addr_d = mem_addr_q;
        last_d     = last_q;
        ovf_d      = ovf_q;
        wcnt_d     = wcnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = FETCH;
                    rom_addr_d = 32'd0;
                    wcnt_d     = 16'd0;
                    ovf_d      = 1'b0;
                    word_d     = 32'd0;
                    last_d     = 1'b0;
                end
            end
            FETCH: begin
                word_d[{rom_addr_q[1:0], 3'b000} +: 8] = rom_byte;
                if (rom_addr_q[1:0] == 2'd3 || rom_done || at_max) begin
                    state_d    = WRITE;
                    mem_addr_d = MEM_BASE + {rom_addr_q[31:2], 2'b00};
                    last_d     = rom_done || at_max;
                    if (at_max && !rom_done) begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    rom_addr_d = rom_addr_q + 32'd1;
                end
            end
            WRITE: begin
                if (mem_write_ack) begin
                    wcnt_d = wcnt_q + 16'd1;
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        state_d    = FETCH;
                        rom_addr_d = rom_addr_q + 32'd1;
                        // Next word starts empty so a short final word reads back zero-padded.
                        word_d     = 32'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rom_addr_q <= 32'd0;
            word_q     <= 32'd0;
            mem_addr_q <= 32'd0;
            last_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wcnt_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            word_q     <= word_d;
            mem_addr_q <= mem_addr_d;
            last_q     <= last_d;
            ovf_q      <= ovf_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign rom_address   = rom_addr_q;
    assign mem_address   = mem_addr_q;
    assign mem_data      = word_q;
    assign mem_write_req = (state_q == WRITE);
    assign busy          = (state_q == FETCH) || (state_q == WRITE);
    assign loaded        = (state_q == DONE);
    assign overflow      = ovf_q;
    assign word_count    = wcnt_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: main instance with a 423-byte ROM, second instance with MAX_BYTES=16 and no rom_done.
module tb_rom_loader;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          LAST = 422;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] rom_address;
    logic [7:0]  rom_byte;
    logic        rom_done;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_write_req;
    logic        mem_write_ack;
    logic        busy;
    logic        loaded;
    logic        overflow;
    logic [15:0] word_count;

    logic        start2;
    logic [31:0] rom_address2;
    logic [7:0]  rom_byte2;
    logic [31:0] mem_address2;
    logic [31:0] mem_data2;
    logic        mem_write_req2;
    logic        busy2;
    logic        loaded2;
    logic        overflow2;
    logic [15:0] word_count2;

    logic [7:0]  rom [0:511];
    int          checks = 0;
    int          errors = 0;
    int          ack_mode = 0;
    int          widx = 0;
    int          hold = 0;
    int          nw = 0;
    logic        prev_busy = 1'b0;
    int          w2 = 0;
    logic        prev_busy2 = 1'b0;

    always #5 clk = ~clk;

    assign rom_byte  = (rom_address < 32'd512) ? rom[rom_address[8:0]] : 8'h00;
    assign rom_done  = (rom_address == 32'(LAST));
    assign rom_byte2 = (rom_address2 < 32'd512) ? rom[rom_address2[8:0]] : 8'h00;

    rom_loader #(.MEM_BASE(BASE), .MAX_BYTES(4096)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rom_address(rom_address), .rom_byte(rom_byte), .rom_done(rom_done),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_write_req(mem_write_req), .mem_write_ack(mem_write_ack),
        .busy(busy), .loaded(loaded), .overflow(overflow), .word_count(word_count)
    );

    rom_loader #(.MEM_BASE(32'h0), .MAX_BYTES(16)) u_dut_ovf (
        .clk(clk), .reset_n(reset_n), .start(start2),
        .rom_address(rom_address2), .rom_byte(rom_byte2), .rom_done(1'b0),
        .mem_address(mem_address2), .mem_data(mem_data2),
        .mem_write_req(mem_write_req2), .mem_write_ack(1'b1),
        .busy(busy2), .loaded(loaded2), .overflow(overflow2), .word_count(word_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int i, input int last);
        logic [31:0] w;
        w = 32'd0;
        for (int lane = 0; lane < 4; lane++) begin
            if (4 * i + lane <= last) w[8*lane +: 8] = rom[4*i+lane];
        end
        return w;
    endfunction

    // Ack driver: tied high in mode 0; in mode 1 ack after 3 wait cycles, plus stray pulses while req is low.
    initial begin
        int cnt;
        cnt = 0;
        mem_write_ack = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 0) begin
                mem_write_ack = 1'b1;
            end else begin
                cnt = mem_write_req ? cnt + 1 : 0;
                mem_write_ack = mem_write_req ? (cnt >= 4) : (busy && rom_address[1:0] == 2'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            widx = 0;
            hold = 0;
            nw   = 0;
        end
        prev_busy = busy;
        if (mem_write_req) begin
            hold++;
            check("wr_addr", mem_address, BASE + 32'(4 * widx));
            check("wr_data", mem_data, exp_word(widx, LAST));
            if (mem_write_ack) begin
                check("req_hold", 32'(hold), (ack_mode != 0) ? 32'd4 : 32'd1);
                if (widx == 2) begin
                    check("w2_addr", mem_address, BASE + 32'd8);
                    check("w2_data", mem_data, 32'h0900140E);
                end
                if (widx == 105) begin
                    check("wlast_addr", mem_address, BASE + 32'd420);
                    check("wlast_data", mem_data, 32'h00000000);
                end
                widx++;
                nw++;
                hold = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (busy2 && !prev_busy2) w2 = 0;
        prev_busy2 = busy2;
        if (mem_write_req2) begin
            check("ovf_addr", mem_address2, 32'(4 * w2));
            check("ovf_data", mem_data2, exp_word(w2, 15));
            w2++;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit poke, output int cyc);
        cyc = 0;
        while (!loaded && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (poke && cyc >= 50 && cyc < 53);
        end
        start = 1'b0;
        check("load_timeout", {31'd0, loaded}, 32'd1);
    endtask

    task automatic finish_checks(input string tag);
        repeat (10) @(posedge clk);
        #1;
        check({tag, "_writes"}, 32'(nw), 32'd106);
        check({tag, "_wcount"}, {16'd0, word_count}, 32'd106);
        check({tag, "_loaded"}, {31'd0, loaded}, 32'd1);
        check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
        check({tag, "_req_idle"}, {31'd0, mem_write_req}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_addr"}, rom_address, 32'd0);
        check({tag, "_mem_addr"}, mem_address, 32'd0);
        check({tag, "_mem_data"}, mem_data, 32'd0);
        check({tag, "_flags"}, {27'd0, mem_write_req, busy, loaded, overflow, 1'b0}, 32'd0);
        check({tag, "_wcount"}, {16'd0, word_count}, 32'd0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 512; i++) rom[i] = 8'((i * 37 + 5) & 255);
        rom[8] = 8'd14; rom[9] = 8'd20; rom[10] = 8'd0; rom[11] = 8'd9;
        rom[420] = 8'd0; rom[421] = 8'd0; rom[422] = 8'd0;
        reset_n = 1'b0;
        start   = 1'b0;
        start2  = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Run 1: ack tied high, stray start while busy must be ignored.
        ack_mode = 0;
        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        wait_done(1'b1, cyc);
        check("throughput_cycles", 32'(cyc), 32'd529);
        finish_checks("run1");

        // Restart straight from DONE with ack delayed by 3 cycles.
        ack_mode = 1;
        pulse_start();
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_wcount", {16'd0, word_count}, 32'd0);
        check("restart_addr", rom_address, 32'd0);
        wait_done(1'b0, cyc);
        finish_checks("run2");

        // Reset in the middle of the 10th write request.
        pulse_start();
        cyc = 0;
        while (!(widx == 9 && mem_write_req) && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("w10_timeout", {31'd0, mem_write_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_idle", {30'd0, busy, mem_write_req}, 32'd0);
        pulse_start();
        wait_done(1'b0, cyc);
        finish_checks("run3");

        // Overflow instance: no rom_done, MAX_BYTES=16.
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        cyc = 0;
        while (!loaded2 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("ovf_loaded", {31'd0, loaded2}, 32'd1);
        check("ovf_flag", {31'd0, overflow2}, 32'd1);
        check("ovf_wcount", {16'd0, word_count2}, 32'd4);
        check("ovf_writes", 32'(w2), 32'd4);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check("ovf_cleared", {31'd0, overflow2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter MEM_BASE, default 32'h0000_0000, RAM byte address where ROM byte 0 lands.
REQ-002 Parameter MAX_BYTES, default 4096, upper bound on ROM bytes read if rom_done never asserts.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  level-sampled request to begin a load; honoured only in IDLE or DONE.
REQ-006 rom_address  output  32  byte address presented to the combinational program ROM.
REQ-007 rom_byte  input  8  ROM data for the current rom_address, valid in the same cycle.
REQ-008 rom_done  input  1  high when rom_address is the last ROM byte; that byte is included in the load.
REQ-009 mem_address  output  32  word-aligned RAM write address.
REQ-010 mem_data  output  32  little-endian assembled word.
REQ-011 mem_write_req  output  1  write request; mem_address and mem_data are stable while it is high.
REQ-012 mem_write_ack  input  1  RAM accepts the write at the rising edge where req and ack are both high.
REQ-013 busy  output  1  high in FETCH and WRITE.
REQ-014 loaded  output  1  high in DONE.
REQ-015 overflow  output  1  sticky; set when MAX_BYTES is reached without rom_done; cleared on each new load.
REQ-016 word_count  output  16  number of words acknowledged in the current load.

Function
REQ-017 The FSM SHALL have four states: IDLE, FETCH, WRITE and DONE.
REQ-018 IDLE or DONE with start=1 at an edge: the block SHALL enter FETCH; rom_address, word_count, overflow and the assembly word are cleared.
REQ-019 FETCH, every edge: rom_byte SHALL be written into lane rom_address[1:0] of the word (lane 0 = bits 7:0).
REQ-020 FETCH: the edge that captures lane 3, a byte with rom_done=1, or byte MAX_BYTES-1 SHALL move the FSM to WRITE; otherwise rom_address increments by 1.
REQ-021 A final partial word SHALL have its unfilled upper lanes set to zero.
REQ-022 Reaching byte MAX_BYTES-1 with rom_done=0 SHALL set overflow, and that word is treated as last.
REQ-023 On entry to WRITE, the block SHALL drive mem_write_req=1 and mem_address = MEM_BASE + (rom_address with bits 1:0 cleared).
REQ-024 mem_write_req SHALL stay high with mem_address and mem_data unchanged until an edge with mem_write_ack=1.
REQ-025 mem_write_ack SHALL be ignored while mem_write_req=0.
REQ-026 At the accepting edge: mem_write_req SHALL drop, word_count increments, and the FSM goes to DONE if the word was last, otherwise to FETCH with rom_address incremented.
REQ-027 Minimum throughput SHALL be 5 cycles per full word: 4 FETCH cycles plus 1 WRITE cycle when ack is already high.
REQ-028 start while busy SHALL be ignored; start held high in DONE SHALL restart the load.
REQ-029 Arithmetic SHALL be modulo 2^32 for addresses and modulo 2^16 for word_count.

Reset
REQ-030 Asserting reset_n low SHALL immediately force IDLE with every output at zero: rom_address, mem_address, mem_data, mem_write_req, busy, loaded, overflow and word_count.
REQ-031 Reset mid-FETCH or mid-WRITE SHALL abandon the load with no further write request; after release the block waits for start.

Verification
REQ-032 ROM model with rom_done at address 422, ack tied high, start pulse -> 106 writes, word_count=106, loaded=1, overflow=0.
REQ-033 Same run, bytes 8..11 = 14,20,0,9 -> write with mem_address=MEM_BASE+8 and mem_data=32'h0900140E.
REQ-034 Final partial word (bytes 420..422 = 0,0,0; lane 3 zero-padded) -> last write at MEM_BASE+420 with data 32'h00000000; no write beyond it.
REQ-035 mem_write_ack delayed 3 cycles on every write -> each req held 4 cycles with address and data stable; total 106 writes; a stray ack pulse while req=0 has no effect.
REQ-036 rom_done never asserted with MAX_BYTES=16 -> 4 writes, overflow=1, loaded=1.
REQ-037 reset_n pulsed low during the 10th write request -> all outputs 0 at once; after release and a new start, the full load completes with 106 writes.
